// File: rtl/hbuf_ddr3_pg_xfer.sv
// DDR3-side page mover for the hit buffer: moves one page between the hbuf DPRAMs
// and the MIG app interface, serving the pg_req/pg_ack 4-phase handshake.
module hbuf_ddr3_pg_xfer #(
    parameter int P_PG_WORDS     = 256,
    parameter int P_ADDR_INC     = 8,
    parameter int P_DPRAM_RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_calib_complete,
    input  logic         pg_req,
    input  logic         pg_optype,
    input  logic [27:0]  pg_addr,
    output logic         pg_ack,
    output logic [7:0]   dpram_rd_addr,
    input  logic [127:0] dpram_dout,
    output logic [7:0]   dpram_wr_addr,
    output logic [127:0] dpram_din,
    output logic         dpram_wren,
    output logic [27:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    output logic [127:0] app_wdf_data,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    input  logic         app_wdf_rdy,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid,
    output logic         busy,
    output logic [15:0]  n_pg_done
);

    localparam int CW = $clog2(P_PG_WORDS + 1);
    localparam int FD = 4;
    localparam logic [CW-1:0] PG_LAST = CW'(P_PG_WORDS - 1);
    localparam logic [CW-1:0] PG_FULL = CW'(P_PG_WORDS);

    typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;

    state_t                    state;
    logic                      sync1, req_s;
    logic [27:0]               base;
    logic [CW-1:0]             cmd_cnt, dat_cnt, rd_cnt;
    logic [P_DPRAM_RD_LAT-1:0] pf_vld;
    logic [127:0]              fifo_mem [FD];
    logic [1:0]                fifo_wp, fifo_rp;
    logic [2:0]                fifo_cnt, occ;

    logic beat_acc, cmd_acc, rd_issue, fifo_push;

    // occ counts prefetched words in flight plus words parked in the FIFO, so a
    // DPRAM read is only launched when its data is guaranteed a slot.
    assign beat_acc  = app_wdf_wren && app_wdf_rdy;
    assign cmd_acc   = app_en && app_rdy;
    assign rd_issue  = (state == WR) && (rd_cnt < PG_FULL) && (occ < 3'(FD));
    assign fifo_push = pf_vld[P_DPRAM_RD_LAT-1];

    assign busy         = (state != IDLE);
    assign app_wdf_wren = (state == WR) && (fifo_cnt != 3'd0);
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = app_wdf_wren ? fifo_mem[fifo_rp] : '0;
    assign app_cmd      = (state == RD) ? 3'b001 : 3'b000;
    assign app_addr     = (state == WR || state == RD)
                        ? base + 28'(cmd_cnt) * 28'(P_ADDR_INC) : '0;
    // A write command never runs ahead of its data beat; the equal case may go
    // out together with the beat being accepted in the same cycle.
    assign app_en = ((state == WR) && ((cmd_cnt < dat_cnt) || (cmd_cnt == dat_cnt && beat_acc)))
                 || ((state == RD) && (cmd_cnt < PG_FULL));

    // NOTE: the FIFO storage carries no reset; nothing reads it until fifo_cnt
    // says an entry is valid, and the output mux forces zero otherwise.
    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo_mem[fifo_wp] <= dpram_dout;
    end

    // NOTE: rst is sampled only at the clock edge, so it belongs inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            sync1         <= 1'b0;
            req_s         <= 1'b0;
            base          <= '0;
            cmd_cnt       <= '0;
            dat_cnt       <= '0;
            rd_cnt        <= '0;
            pf_vld        <= '0;
            fifo_wp       <= '0;
            fifo_rp       <= '0;
            fifo_cnt      <= '0;
            occ           <= '0;
            pg_ack        <= 1'b0;
            n_pg_done     <= '0;
            dpram_rd_addr <= '0;
            dpram_wr_addr <= '0;
            dpram_din     <= '0;
            dpram_wren    <= 1'b0;
        end else begin
            sync1 <= pg_req;
            req_s <= sync1;
            case (state)
                IDLE: begin
                    if (req_s && !pg_ack && init_calib_complete) begin
                        base          <= pg_addr;
                        cmd_cnt       <= '0;
                        dat_cnt       <= '0;
                        rd_cnt        <= '0;
                        pf_vld        <= '0;
                        fifo_wp       <= '0;
                        fifo_rp       <= '0;
                        fifo_cnt      <= '0;
                        occ           <= '0;
                        dpram_rd_addr <= '0;
                        state         <= pg_optype ? RD : WR;
                    end
                end
                WR: begin
                    if (rd_issue) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt != PG_LAST)
                            dpram_rd_addr <= dpram_rd_addr + 8'd1;
                    end
                    pf_vld[0] <= rd_issue;
                    for (int i = 1; i < P_DPRAM_RD_LAT; i++)
                        pf_vld[i] <= pf_vld[i-1];
                    if (fifo_push) fifo_wp <= fifo_wp + 2'd1;
                    if (beat_acc)  fifo_rp <= fifo_rp + 2'd1;
                    fifo_cnt <= fifo_cnt + 3'(fifo_push) - 3'(beat_acc);
                    occ      <= occ + 3'(rd_issue) - 3'(beat_acc);
                    if (beat_acc) dat_cnt <= dat_cnt + 1'b1;
                    if (cmd_acc)  cmd_cnt <= cmd_cnt + 1'b1;
                    if (cmd_cnt == PG_FULL && dat_cnt == PG_FULL) begin
                        state     <= ACK;
                        pg_ack    <= 1'b1;
                        n_pg_done <= n_pg_done + 16'd1;
                    end
                end
                RD: begin
                    if (cmd_acc) cmd_cnt <= cmd_cnt + 1'b1;
                    dpram_wren <= 1'b0;
                    if (app_rd_data_valid && dat_cnt < PG_FULL) begin
                        dpram_wren    <= 1'b1;
                        dpram_din     <= app_rd_data;
                        dpram_wr_addr <= 8'(dat_cnt);
                        dat_cnt       <= dat_cnt + 1'b1;
                    end
                    // The last wren is already on the port once dat_cnt is full.
                    if (dat_cnt == PG_FULL) begin
                        state     <= ACK;
                        pg_ack    <= 1'b1;
                        n_pg_done <= n_pg_done + 16'd1;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        pg_ack <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hbuf_ddr3_pg_xfer.sv
// Self-checking bench for hbuf_ddr3_pg_xfer: DPRAM and MIG models, a transaction
// monitor, and a page-level reference built from the page/address rules.
module tb_hbuf_ddr3_pg_xfer;

    localparam int PG  = 256;
    localparam int INC = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         init_calib_complete = 1'b1;
    logic         pg_req = 1'b0;
    logic         pg_optype = 1'b0;
    logic [27:0]  pg_addr = '0;
    logic         pg_ack;
    logic [7:0]   dpram_rd_addr;
    logic [127:0] dpram_dout = '0;
    logic [7:0]   dpram_wr_addr;
    logic [127:0] dpram_din;
    logic         dpram_wren;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy = 1'b1;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy = 1'b1;
    logic [127:0] app_rd_data = '0;
    logic         app_rd_data_valid = 1'b0;
    logic         busy;
    logic [15:0]  n_pg_done;

    hbuf_ddr3_pg_xfer dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .pg_req(pg_req), .pg_optype(pg_optype), .pg_addr(pg_addr), .pg_ack(pg_ack),
        .dpram_rd_addr(dpram_rd_addr), .dpram_dout(dpram_dout),
        .dpram_wr_addr(dpram_wr_addr), .dpram_din(dpram_din), .dpram_wren(dpram_wren),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .busy(busy), .n_pg_done(n_pg_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_pages = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DPRAM models: source page (1-cycle registered read) and readback sink.
    logic [127:0] src_mem [PG];
    logic [127:0] rb_mem [PG];
    int rb_wren_cnt = 0;
    always @(posedge clk) begin
        dpram_dout <= src_mem[dpram_rd_addr];
        if (dpram_wren) begin
            rb_mem[dpram_wr_addr] <= dpram_din;
            rb_wren_cnt <= rb_wren_cnt + 1;
        end
    end

    // MIG model: optional random back-pressure, in-order read returns of data=addr.
    typedef struct { logic [27:0] addr; int due; } rd_rsp_t;
    typedef struct { logic [2:0] cmd; logic [27:0] addr; } cmd_t;
    rd_rsp_t rdq[$];
    bit rand_rdy = 1'b0;
    bit stray_valid = 1'b0;
    int last_due = 0;

    always @(posedge clk) begin
        #1;
        app_rdy     = init_calib_complete && (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        app_wdf_rdy = init_calib_complete && (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        if (stray_valid) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
        end else if (rdq.size() > 0 && rdq[0].due <= cyc) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = {100'd0, rdq[0].addr};
            void'(rdq.pop_front());
        end else begin
            app_rd_data_valid = 1'b0;
            app_rd_data       = '0;
        end
    end

    // Monitor: logs accepted commands/beats and tracks handshake discipline.
    cmd_t         cmd_log[$];
    logic [127:0] beat_log[$];
    int hold_err = 0, order_err = 0, end_err = 0, en_seen = 0, wr_cmds = 0;
    logic         prev_en_stall = 1'b0, prev_wd_stall = 1'b0;
    logic [27:0]  prev_addr;
    logic [2:0]   prev_cmd;
    logic [127:0] prev_wdata;
    cmd_t         mon_c;
    rd_rsp_t      mon_r;

    always @(negedge clk) begin
        if (!rst) begin
            prev_en_stall = 1'b0;
            prev_wd_stall = 1'b0;
        end else begin
            if (app_en) en_seen++;
            if (prev_en_stall && (!app_en || app_addr !== prev_addr || app_cmd !== prev_cmd)) hold_err++;
            if (prev_wd_stall && (!app_wdf_wren || app_wdf_data !== prev_wdata)) hold_err++;
            if (app_wdf_end !== app_wdf_wren) end_err++;
            if (app_en && app_rdy) begin
                mon_c.cmd  = app_cmd;
                mon_c.addr = app_addr;
                cmd_log.push_back(mon_c);
                if (app_cmd == 3'b000) wr_cmds++;
                if (app_cmd == 3'b001) begin
                    mon_r.addr = app_addr;
                    mon_r.due  = cyc + int'($urandom_range(10, 40));
                    if (mon_r.due <= last_due) mon_r.due = last_due + 1;
                    last_due = mon_r.due;
                    rdq.push_back(mon_r);
                end
            end
            if (app_wdf_wren && app_wdf_rdy) beat_log.push_back(app_wdf_data);
            if (wr_cmds > beat_log.size()) order_err++;
            prev_en_stall = app_en && !app_rdy;
            prev_wd_stall = app_wdf_wren && !app_wdf_rdy;
            prev_addr     = app_addr;
            prev_cmd      = app_cmd;
            prev_wdata    = app_wdf_data;
        end
    end

    function automatic logic [324:0] outs_vec();
        return {pg_ack, dpram_rd_addr, dpram_wr_addr, dpram_din, dpram_wren, app_addr, app_cmd,
                app_en, app_wdf_data, app_wdf_wren, app_wdf_end, busy, n_pg_done};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        beat_log.delete();
        wr_cmds = 0; hold_err = 0; order_err = 0; end_err = 0; en_seen = 0;
    endtask

    task automatic start_req(input bit op, input logic [27:0] a);
        @(posedge clk);
        #1;
        pg_optype = op;
        pg_addr   = a;
        pg_req    = 1'b1;
    endtask

    // lat = cycles spent busy before pg_ack rose.
    task automatic wait_ack(input string name, input int budget, output int lat);
        int n = 0;
        lat = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (pg_ack) break;
            if (busy) lat++;
        end
        checks++;
        if (pg_ack !== 1'b1) begin
            failures++;
            $display("FAIL %s_ack: pg_ack=%b after %0d clks, required 1", name, pg_ack, budget);
        end else exp_pages++;
    endtask

    task automatic release_req(input string name);
        int n = 0;
        @(posedge clk);
        #1 pg_req = 1'b0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (!pg_ack) break;
        end
        checks++;
        if (pg_ack !== 1'b0 || n < 2 || n > 3) begin
            failures++;
            $display("FAIL %s_release: pg_ack=%b fell after %0d clks, required 2..3", name, pg_ack, n);
        end
    endtask

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_write_page(input string name, input logic [27:0] b);
        int bad_c = 0, bad_d = 0;
        for (int k = 0; k < PG; k++) begin
            if (k < cmd_log.size() && (cmd_log[k].cmd !== 3'b000 || cmd_log[k].addr !== b + 28'(k * INC))) bad_c++;
            if (k < beat_log.size() && beat_log[k] !== src_mem[k]) bad_d++;
        end
        check_eq({name, "_ncmd"}, cmd_log.size(), PG);
        check_eq({name, "_nbeat"}, beat_log.size(), PG);
        check_eq({name, "_bad_cmds"}, bad_c, 0);
        check_eq({name, "_bad_beats"}, bad_d, 0);
        check_eq({name, "_hold_err"}, hold_err, 0);
        check_eq({name, "_cmd_ahead"}, order_err, 0);
        check_eq({name, "_wdf_end"}, end_err, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        @(negedge clk);
        checks++;
        if (outs_vec() !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, expected all 0", outs_vec());
        end
        @(posedge clk);
        #1 rst = 1'b1;
        tick(2);
    endtask

    task automatic test_write_basic();
        int lat;
        for (int k = 0; k < PG; k++) src_mem[k] = 128'(k);
        rand_rdy = 1'b0;
        clear_logs();
        start_req(1'b0, 28'h0000500);
        wait_ack("wr_basic", 2000, lat);
        checks++;
        if (lat > PG + 8) begin
            failures++;
            $display("FAIL wr_basic_latency: got %0d clks, expected <= %0d", lat, PG + 8);
        end
        release_req("wr_basic");
        check_write_page("wr_basic", 28'h0000500);
        check_eq("wr_basic_npg", n_pg_done, exp_pages);
    endtask

    task automatic test_write_random();
        int lat;
        for (int k = 0; k < PG; k++) src_mem[k] = {$urandom, $urandom, $urandom, $urandom};
        rand_rdy = 1'b1;
        clear_logs();
        start_req(1'b0, 28'h0000500);
        wait_ack("wr_rand", 5000, lat);
        release_req("wr_rand");
        rand_rdy = 1'b0;
        check_write_page("wr_rand", 28'h0000500);
        check_eq("wr_rand_npg", n_pg_done, exp_pages);
    endtask

    task automatic test_read();
        int lat, w0, bad_m = 0, bad_c = 0;
        for (int k = 0; k < PG; k++) rb_mem[k] = '1;
        w0 = rb_wren_cnt;
        clear_logs();
        start_req(1'b1, 28'h0000F00);
        wait_ack("rd", 5000, lat);
        release_req("rd");
        for (int k = 0; k < PG; k++) begin
            if (rb_mem[k] !== 128'(28'h0000F00 + 28'(k * INC))) bad_m++;
            if (k < cmd_log.size() && (cmd_log[k].cmd !== 3'b001 || cmd_log[k].addr !== 28'h0000F00 + 28'(k * INC))) bad_c++;
        end
        check_eq("rd_ncmd", cmd_log.size(), PG);
        check_eq("rd_bad_cmds", bad_c, 0);
        check_eq("rd_bad_words", bad_m, 0);
        check_eq("rd_nwren", rb_wren_cnt - w0, PG);
        check_eq("rd_hold_err", hold_err, 0);
        check_eq("rd_npg", n_pg_done, exp_pages);
        // Read data arriving while idle must not reach the readback DPRAM.
        w0 = rb_wren_cnt;
        @(posedge clk);
        #2 stray_valid = 1'b1;
        tick(5);
        #2 stray_valid = 1'b0;
        tick(3);
        check_eq("stray_rd_wren", rb_wren_cnt - w0, 0);
        check_eq("stray_rd_busy", busy, 0);
    endtask

    task automatic test_handshake();
        int lat, width = 0, n = 0;
        for (int k = 0; k < PG; k++) src_mem[k] = 128'(k * 3 + 1);
        init_calib_complete = 1'b0;
        clear_logs();
        start_req(1'b0, 28'h0001000);
        tick(100);
        check_eq("calib_no_app_en", en_seen, 0);
        check_eq("calib_not_busy", busy, 0);
        #1 init_calib_complete = 1'b1;
        wait_ack("calib", 2000, lat);
        release_req("calib");
        check_write_page("calib", 28'h0001000);
        // Back-to-back request straight after the previous ack falls.
        clear_logs();
        start_req(1'b0, 28'h0002000);
        wait_ack("b2b", 2000, lat);
        release_req("b2b");
        check_write_page("b2b", 28'h0002000);
        check_eq("b2b_npg", n_pg_done, exp_pages);
        // Request withdrawn mid-page: page still completes, ack is a 1-cycle pulse.
        start_req(1'b0, 28'h0003000);
        tick(20);
        #1 pg_req = 1'b0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (pg_ack) width++;
            if (width > 0 && !pg_ack && !busy) break;
        end
        exp_pages++;
        check_eq("early_drop_ack_width", width, 1);
        check_eq("early_drop_npg", n_pg_done, exp_pages);
    endtask

    task automatic test_reset_mid();
        int lat, n = 0;
        for (int k = 0; k < PG; k++) src_mem[k] = 128'(k);
        clear_logs();
        start_req(1'b0, 28'h0000500);
        while (n < 1000 && beat_log.size() < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("rst_mid_reached_beat100", (beat_log.size() >= 100) ? 1 : 0, 1);
        rst = 1'b0;
        pg_req = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (outs_vec() !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got %h, expected all 0", outs_vec());
        end
        exp_pages = 0;
        tick(2);
        #1 rst = 1'b1;
        tick(2);
        clear_logs();
        start_req(1'b0, 28'h0000500);
        wait_ack("rst_restart", 2000, lat);
        release_req("rst_restart");
        check_write_page("rst_restart", 28'h0000500);
        check_eq("rst_restart_npg", n_pg_done, exp_pages);
    endtask

    initial begin
        for (int k = 0; k < PG; k++) src_mem[k] = '0;
        test_reset();
        test_write_basic();
        test_write_random();
        test_read();
        test_handshake();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
